// File: rtl/rgb2yuv_skin_pipe.sv
// rtl/rgb2yuv_skin_pipe.sv - 4-stage RGB->YCbCr converter with skin flag and per-frame skin count
module rgb2yuv_skin_pipe #(
  parameter int PIX_W = 8,
  parameter int FRAC  = 8,
  parameter int U_MIN = 73,
  parameter int U_MAX = 122,
  parameter int V_MIN = 132,
  parameter int V_MAX = 173,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PIX_W-1:0] i_red,
  input  logic [PIX_W-1:0] i_grn,
  input  logic [PIX_W-1:0] i_blu,
  input  logic             i_mode,
  input  logic             i_eof,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PIX_W-1:0] o_y,
  output logic [PIX_W-1:0] o_u,
  output logic [PIX_W-1:0] o_v,
  output logic             o_skin,
  output logic             o_eof,
  output logic [CNT_W-1:0] o_skin_cnt,
  output logic             o_cnt_stb
);

  // Coefficient magnitude stays below 2^FRAC, so FRAC+2 bits holds it signed with margin.
  localparam int CW     = FRAC + 2;
  // Each product is below 2^(PIX_W+FRAC) in magnitude; one extra bit for sign, one spare.
  localparam int PROD_W = PIX_W + FRAC + 2;
  localparam int SUM_W  = PIX_W + FRAC + 4;

  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(1) << (FRAC - 1);
  localparam logic signed [SUM_W-1:0] OFF_16  = SUM_W'(16) << (PIX_W - 8);
  localparam logic signed [SUM_W-1:0] OFF_128 = SUM_W'(128) << (PIX_W - 8);
  localparam logic signed [SUM_W-1:0] MAXV    = (SUM_W'(1) << PIX_W) - SUM_W'(1);
  localparam logic [7:0] U_LO = 8'(U_MIN);
  localparam logic [7:0] U_HI = 8'(U_MAX);
  localparam logic [7:0] V_LO = 8'(V_MIN);
  localparam logic [7:0] V_HI = 8'(V_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Matrix entries 0-2 feed Y, 3-5 feed Cb, 6-8 feed Cr; columns are R, G, B.
  function automatic logic signed [CW-1:0] coef(input logic mode, input int idx);
    int k;
    k = 0;
    if (!mode) begin
      case (idx)
        0: k = 66;   1: k = 129;  2: k = 25;
        3: k = -38;  4: k = -74;  5: k = 112;
        6: k = 112;  7: k = -94;  8: k = -18;
        default: k = 0;
      endcase
    end else begin
      case (idx)
        0: k = 77;   1: k = 150;  2: k = 29;
        3: k = -43;  4: k = -85;  5: k = 128;
        6: k = 128;  7: k = -107; 8: k = -21;
        default: k = 0;
      endcase
    end
    return CW'(k * (1 << (FRAC - 8)));
  endfunction

  function automatic logic signed [PROD_W-1:0] mul(input logic [PIX_W-1:0] p,
                                                   input logic signed [CW-1:0] c);
    logic signed [PROD_W-1:0] pe;
    logic signed [PROD_W-1:0] ce;
    pe = $signed({{(PROD_W - PIX_W){1'b0}}, p});
    ce = $signed({{(PROD_W - CW){c[CW-1]}}, c});
    return pe * ce;
  endfunction

  function automatic logic signed [SUM_W-1:0] ext(input logic signed [PROD_W-1:0] p);
    return $signed({{(SUM_W - PROD_W){p[PROD_W-1]}}, p});
  endfunction

  function automatic logic [PIX_W-1:0] clampv(input logic signed [SUM_W-1:0] s);
    if (s < 0)
      return '0;
    else if (s > MAXV)
      return '1;
    else
      return s[PIX_W-1:0];
  endfunction

  logic adv;
  logic s0_vld, s1_vld, s2_vld;
  logic s0_mode, s1_mode, s2_mode;
  logic s0_eof, s1_eof, s2_eof;
  logic [PIX_W-1:0] s0_r, s0_g, s0_b;
  logic signed [PROD_W-1:0] s1_p [9];
  logic signed [SUM_W-1:0] s2_y, s2_u, s2_v;
  logic [PIX_W-1:0] y_c, u_c, v_c;
  logic skin_c;
  logic [7:0] u8, v8;
  logic [CNT_W-1:0] run_cnt, run_inc;
  logic hs;

  // A single stall signal freezes every stage, so the output registers hold while blocked.
  assign adv     = !o_valid | i_ready;
  assign o_ready = adv;
  assign hs      = o_valid & i_ready;

  // Pixel data path registers; qualified by the stage valids, so no reset needed.
  always_ff @(posedge clk) begin
    if (adv) begin
      s0_r    <= i_red;
      s0_g    <= i_grn;
      s0_b    <= i_blu;
      s0_mode <= i_mode;
      s0_eof  <= i_eof;
      for (int k = 0; k < 9; k++) begin
        s1_p[k] <= mul((k % 3 == 0) ? s0_r : (k % 3 == 1) ? s0_g : s0_b, coef(s0_mode, k));
      end
      s1_mode <= s0_mode;
      s1_eof  <= s0_eof;
      s2_y    <= ext(s1_p[0]) + ext(s1_p[1]) + ext(s1_p[2]) + RND;
      s2_u    <= ext(s1_p[3]) + ext(s1_p[4]) + ext(s1_p[5]) + RND;
      s2_v    <= ext(s1_p[6]) + ext(s1_p[7]) + ext(s1_p[8]) + RND;
      s2_mode <= s1_mode;
      s2_eof  <= s1_eof;
    end
  end

  // Final stage: floor shift, offset, clamp, and skin test on the clamped chroma.
  always_comb begin
    y_c    = clampv((s2_y >>> FRAC) + (s2_mode ? SUM_W'(0) : OFF_16));
    u_c    = clampv((s2_u >>> FRAC) + OFF_128);
    v_c    = clampv((s2_v >>> FRAC) + OFF_128);
    u8     = u_c[PIX_W-1 -: 8];
    v8     = v_c[PIX_W-1 -: 8];
    skin_c = (u8 >= U_LO) && (u8 <= U_HI) && (v8 >= V_LO) && (v8 <= V_HI);
  end

  // Stage valids and output registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld  <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      o_valid <= 1'b0;
      o_y     <= '0;
      o_u     <= '0;
      o_v     <= '0;
      o_skin  <= 1'b0;
      o_eof   <= 1'b0;
    end else if (adv) begin
      s0_vld  <= i_valid;
      s1_vld  <= s0_vld;
      s2_vld  <= s1_vld;
      o_valid <= s2_vld;
      o_y     <= y_c;
      o_u     <= u_c;
      o_v     <= v_c;
      o_skin  <= skin_c;
      o_eof   <= s2_eof;
    end
  end

  assign run_inc = (o_skin && run_cnt != CNT_MAX) ? run_cnt + CNT_W'(1) : run_cnt;

  // Skin accumulation on accepted outputs only; eof publishes the frame total and restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt    <= '0;
      o_skin_cnt <= '0;
      o_cnt_stb  <= 1'b0;
    end else begin
      o_cnt_stb <= 1'b0;
      if (hs) begin
        if (o_eof) begin
          o_skin_cnt <= run_inc;
          run_cnt    <= '0;
          o_cnt_stb  <= 1'b1;
        end else begin
          run_cnt <= run_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb2yuv_skin_pipe.sv
// tb/tb_rgb2yuv_skin_pipe.sv - scoreboard bench for rgb2yuv_skin_pipe
module tb_rgb2yuv_skin_pipe;
  localparam int PIX_W = 8;
  localparam int CNT_W = 22;
  localparam int COEF [2][9] = '{'{66, 129, 25, -38, -74, 112, 112, -94, -18},
                                 '{77, 150, 29, -43, -85, 128, 128, -107, -21}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic o_ready;
  logic [PIX_W-1:0] i_red = '0, i_grn = '0, i_blu = '0;
  logic i_mode = 1'b0, i_eof = 1'b0;
  logic o_valid;
  logic i_ready = 1'b1;
  logic [PIX_W-1:0] o_y, o_u, o_v;
  logic o_skin, o_eof;
  logic [CNT_W-1:0] o_skin_cnt;
  logic o_cnt_stb;

  typedef struct {int y; int u; int v; int skin; int eof; int cyc; int lat;} exp_t;
  exp_t q[$];
  int cq[$];
  int checks = 0, errors = 0, cyc = 0, run_cnt = 0, stb_seen = 0;
  int rdy_mode = 0, lat_en = 0;
  int d_has = 0, d_y = 0, d_u = 0, d_v = 0, d_s = 0;
  int held = 0, hold_val = 0;

  always #5 clk = ~clk;

  rgb2yuv_skin_pipe dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_red(i_red), .i_grn(i_grn), .i_blu(i_blu), .i_mode(i_mode), .i_eof(i_eof),
    .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y), .o_u(o_u), .o_v(o_v),
    .o_skin(o_skin), .o_eof(o_eof), .o_skin_cnt(o_skin_cnt), .o_cnt_stb(o_cnt_stb)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp8(input int x);
    return (x < 0) ? 0 : (x > 255) ? 255 : x;
  endfunction

  // Reference: rounded matrix product with floor shift, offset, clamp, then skin window test.
  function automatic exp_t model(input int r, input int g, input int b, input int m, input int e);
    exp_t t;
    int res [3];
    int off [3];
    off = '{(m != 0) ? 0 : 16, 128, 128};
    for (int ch = 0; ch < 3; ch++) begin
      res[ch] = COEF[m][3*ch] * r + COEF[m][3*ch+1] * g + COEF[m][3*ch+2] * b;
      res[ch] = clamp8(((res[ch] + 128) >>> 8) + off[ch]);
    end
    t.y = res[0];
    t.u = res[1];
    t.v = res[2];
    t.skin = (t.u >= 73 && t.u <= 122 && t.v >= 132 && t.v <= 173) ? 1 : 0;
    t.eof = e;
    t.cyc = 0;
    t.lat = 0;
    return t;
  endfunction

  // Downstream ready generator: 0 = always ready, 1 = random, 2 = held low.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: i_ready = 1'b1;
      1: i_ready = ($urandom_range(0, 3) != 0);
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor/scoreboard, sampled at the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      cq.delete();
      run_cnt = 0;
      held = 0;
    end else begin
      if (held != 0)
        chk("frozen", {5'd0, o_valid, o_y, o_u, o_v, o_skin, o_eof}, hold_val);
      chk("o_ready", int'(o_ready), int'(!o_valid || i_ready));
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("y", int'(o_y), e.y);
          chk("u", int'(o_u), e.u);
          chk("v", int'(o_v), e.v);
          chk("skin", int'(o_skin), e.skin);
          chk("eof", int'(o_eof), e.eof);
          // pushed half a cycle before the accept edge; valid follows 3 edges later
          if (e.lat != 0) chk("latency", cyc - e.cyc, 4);
          if (e.skin != 0 && run_cnt < (1 << CNT_W) - 1) run_cnt++;
          if (e.eof != 0) begin
            cq.push_back(run_cnt);
            run_cnt = 0;
          end
        end
      end
      if (o_cnt_stb) begin
        stb_seen++;
        if (cq.size() == 0) chk("cnt_stb_unexp", 1, 0);
        else chk("skin_cnt", int'(o_skin_cnt), cq.pop_front());
      end
      held = (o_valid && !i_ready) ? 1 : 0;
      hold_val = {5'd0, o_valid, o_y, o_u, o_v, o_skin, o_eof};
      if (i_valid && o_ready) begin
        if (d_has != 0) begin
          e.y = d_y; e.u = d_u; e.v = d_v; e.skin = d_s; e.eof = int'(i_eof);
        end else begin
          e = model(int'(i_red), int'(i_grn), int'(i_blu), int'(i_mode), int'(i_eof));
        end
        e.cyc = cyc;
        e.lat = lat_en;
        q.push_back(e);
      end
    end
  end

  // Offer one pixel; returns at posedge+1 after the accept edge.
  task automatic px(input int r, input int g, input int b, input int m, input int eo,
                    input int has, input int ey, input int eu, input int ev, input int es);
    int t;
    i_red = 8'(r); i_grn = 8'(g); i_blu = 8'(b);
    i_mode = m[0]; i_eof = eo[0];
    d_has = has; d_y = ey; d_u = eu; d_v = ev; d_s = es;
    i_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_ready && t < 300);
    if (!o_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_eof = 1'b0;
    d_has = 0;
  endtask

  task automatic rpx(input int m, input int eo);
    px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), m, eo, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int stb0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_yuv", int'({o_y, o_u, o_v}), 0);
    chk("rst_skin_eof", int'({o_skin, o_eof}), 0);
    chk("rst_cnt", int'(o_skin_cnt), 0);
    chk("rst_stb", int'(o_cnt_stb), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Known conversions, back-to-back, no backpressure, latency checked.
    lat_en = 1;
    px(0, 0, 0, 0, 0, 1, 16, 128, 128, 0);
    px(255, 255, 255, 0, 0, 1, 235, 128, 128, 0);
    px(255, 255, 255, 1, 0, 1, 255, 128, 128, 0);
    px(255, 0, 0, 0, 0, 1, 82, 90, 240, 0);
    px(200, 150, 120, 0, 0, 1, 155, 107, 152, 1);
    px(200, 150, 120, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) rpx(i % 2, 0);
    drain();
    lat_en = 0;

    // Five-cycle downstream stall in the middle of an 8-pixel stream.
    fork
      begin
        for (int i = 0; i < 8; i++) rpx($urandom_range(0, 1), 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    drain();

    // Close the running frame, then a 10-pixel frame holding 4 skin pixels, with stalls.
    px(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drain();
    rdy_mode = 1;
    stb0 = stb_seen;
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 4 || i == 6 || i == 9) px(200, 150, 120, 0, (i == 9) ? 1 : 0, 0, 0, 0, 0, 0);
      else px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    drain();
    chk("frame_cnt", int'(o_skin_cnt), 4);
    chk("frame_stb", stb_seen - stb0, 1);
    stb0 = stb_seen;
    for (int i = 0; i < 10; i++) rpx($urandom_range(0, 1), (i == 9) ? 1 : 0);
    drain();
    chk("frame2_stb", stb_seen - stb0, 1);

    // Random traffic with idle gaps, random stalls and random frame ends.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0)
        px(200 - $urandom_range(0, 20), 150, 120 - $urandom_range(0, 20), 0, ($urandom_range(0, 15) == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      else
        rpx($urandom_range(0, 1), ($urandom_range(0, 15) == 0) ? 1 : 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Reset with three pixels (eof last) in flight: nothing emerges, nothing is published.
    rdy_mode = 0;
    drain();
    px(200, 150, 120, 0, 0, 0, 0, 0, 0, 0);
    px(200, 150, 120, 0, 0, 0, 0, 0, 0, 0);
    px(200, 150, 120, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst6_o_valid", int'(o_valid), 0);
    chk("rst6_stb", int'(o_cnt_stb), 0);
    chk("rst6_cnt", int'(o_skin_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stb0 = stb_seen;
    repeat (6) @(posedge clk);
    #1;
    chk("rst6_no_stb", stb_seen - stb0, 0);
    px(200, 150, 120, 0, 0, 0, 0, 0, 0, 0);
    px(10, 20, 30, 1, 0, 0, 0, 0, 0, 0);
    px(200, 150, 120, 0, 1, 0, 0, 0, 0, 0);
    drain();
    chk("restart_cnt", int'(o_skin_cnt), 2);

    chk("queue_empty", q.size(), 0);
    chk("cnt_queue_empty", cq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
